// File: rtl/hex_display_scanner.sv
// Eight-digit multiplexed seven-segment scanner for a 32-bit debug value.
// The value is captured once per frame, so every digit in a frame comes from one snapshot.
module hex_display_scanner #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic        hold_i,
   input  logic [7:0]  dig_en_i,
   input  logic        lz_blank_i,
   input  logic [7:0]  dp_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic        frame_o
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] pre_reg;
   logic [2:0]    digit_reg;
   logic [31:0]   shadow_reg;
   logic          active_reg;
   logic [7:0]    an_reg;
   logic [6:0]    seg_reg;
   logic          dp_reg;
   logic          frame_reg;

   logic          tick;
   logic          frame_start;
   logic [2:0]    digit_next;
   logic [31:0]   shadow_next;
   logic          active_next;
   logic [3:0]    nib [8];
   logic [7:0]    upper_zero;
   logic          lz_hit;
   logic          lit;
   logic [7:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick        = (pre_reg == PRE_MAX);
   assign frame_start = tick && (digit_reg == 3'd7);
   assign digit_next  = digit_reg + 3'd1;
   assign shadow_next = (frame_start && !hold_i) ? data_i : shadow_reg;
   assign active_next = active_reg | frame_start;

   // upper_zero[k]: nibbles k..7 of the upcoming snapshot are all zero
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_nib
         assign nib[gi]        = shadow_next[4*gi +: 4];
         assign upper_zero[gi] = ((shadow_next >> (4*gi)) == 32'd0);
      end
   endgenerate

   assign lz_hit = lz_blank_i && (digit_next != 3'd0) && upper_zero[digit_next];
   assign lit    = active_next && dig_en_i[digit_next] && !lz_hit;

   always_comb begin
      an_next  = 8'hFF;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      if (lit) begin
         an_next  = ~(8'b1 << digit_next);
         seg_next = decode(nib[digit_next]);
         dp_next  = ~dp_i[digit_next];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_reg    <= '0;
         digit_reg  <= 3'd7;
         shadow_reg <= 32'd0;
         active_reg <= 1'b0;
         an_reg     <= 8'hFF;
         seg_reg    <= 7'h7F;
         dp_reg     <= 1'b1;
         frame_reg  <= 1'b0;
      end else begin
         frame_reg <= 1'b0;
         pre_reg   <= tick ? '0 : pre_reg + PW'(1);
         if (tick) begin
            digit_reg  <= digit_next;
            shadow_reg <= shadow_next;
            active_reg <= active_next;
            frame_reg  <= frame_start;
            an_reg     <= an_next;
            seg_reg    <= seg_next;
            dp_reg     <= dp_next;
         end
      end
   end

   assign an_o    = an_reg;
   assign seg_o   = seg_reg;
   assign dp_o    = dp_reg;
   assign frame_o = frame_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: fixed vectors, corner sequences and a
// free-running reference model driven by random stimulus.
module tb_hex_display_scanner;

   localparam int DIV = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] data_i;
   logic        hold_i;
   logic [7:0]  dig_en_i;
   logic        lz_blank_i;
   logic [7:0]  dp_i;
   logic [7:0]  an_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic        frame_o;

   int checks = 0;
   int errors = 0;

   hex_display_scanner #(.REFRESH_DIV(DIV)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .hold_i(hold_i),
      .dig_en_i(dig_en_i), .lz_blank_i(lz_blank_i), .dp_i(dp_i),
      .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o), .frame_o(frame_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: digit position follows from the number of edges since reset.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          m_n;
   int          m_k;
   bit          m_valid = 0;
   logic [31:0] m_shadow;
   bit          m_active;
   logic [7:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dp;
   logic        m_frame;
   logic [7:0]  m_one;
   bit          m_blank;

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_n = 0; m_shadow = 0; m_active = 0;
         m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_frame = 1'b0;
         m_valid = 1;
      end else begin
         m_n++;
         m_frame = 1'b0;
         if (m_n % DIV == 0) begin
            m_k = ((m_n / DIV) - 1) % 8;
            if (m_k == 0) begin
               if (!hold_i) m_shadow = data_i;
               m_active = 1;
               m_frame  = 1'b1;
            end
            m_blank = lz_blank_i && (m_k != 0) && ((m_shadow >> (4 * m_k)) == 0);
            if (m_active && dig_en_i[m_k] && !m_blank) begin
               m_one = 8'd1 << m_k;
               m_an  = ~m_one;
               m_seg = seg_tab[(m_shadow >> (4 * m_k)) & 32'hF];
               m_dp  = ~dp_i[m_k];
            end else begin
               m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
            end
         end
      end
      #1;
      if (m_valid) begin
         chk("model_an", {24'd0, an_o}, {24'd0, m_an});
         chk("model_seg", {25'd0, seg_o}, {25'd0, m_seg});
         chk("model_dp", {31'd0, dp_o}, {31'd0, m_dp});
         chk("model_frame", {31'd0, frame_o}, {31'd0, m_frame});
      end
   end

   typedef struct {
      int         edge_n;
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
   } vec_t;

   vec_t tab [9];
   int   e;

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic go(input int target);
      step(target - e);
      e = target;
   endtask

   task automatic pulse_reset();
      @(negedge clk_i) rst_i = 1'b1;
      @(negedge clk_i) rst_i = 1'b0;
      e = 0;
   endtask

   task automatic run_table();
      e = 0;
      for (int i = 0; i < 9; i++) begin
         go(tab[i].edge_n);
         chk($sformatf("tab%0d_an", i), {24'd0, an_o}, {24'd0, tab[i].an});
         chk($sformatf("tab%0d_seg", i), {25'd0, seg_o}, {25'd0, tab[i].seg});
         chk($sformatf("tab%0d_dp", i), {31'd0, dp_o}, {31'd0, tab[i].dp});
         chk($sformatf("tab%0d_frame", i), {31'd0, frame_o}, {31'd0, tab[i].frame});
         $display("vec %0d edge %0d an=%h seg=%h dp=%b frame=%b", i, tab[i].edge_n, an_o, seg_o, dp_o, frame_o);
      end
   endtask

   task automatic set_inputs(input logic [31:0] d, input logic h, input logic [7:0] en,
                             input logic lz, input logic [7:0] dp);
      data_i = d; hold_i = h; dig_en_i = en; lz_blank_i = lz; dp_i = dp;
   endtask

   int         fr_edges [$];
   logic [7:0] exp_an;

   initial begin
      tab[0] = '{1,  8'hFF, 7'h7F, 1'b1, 1'b0};
      tab[1] = '{2,  8'hFF, 7'h7F, 1'b1, 1'b0};
      tab[2] = '{3,  8'hFF, 7'h7F, 1'b1, 1'b0};
      tab[3] = '{4,  8'hFE, 7'h00, 1'b1, 1'b1};
      tab[4] = '{5,  8'hFE, 7'h00, 1'b1, 1'b0};
      tab[5] = '{8,  8'hFD, 7'h78, 1'b1, 1'b0};
      tab[6] = '{32, 8'h7F, 7'h79, 1'b1, 1'b0};
      tab[7] = '{35, 8'h7F, 7'h79, 1'b1, 1'b0};
      tab[8] = '{36, 8'hFE, 7'h00, 1'b1, 1'b1};

      rst_i = 1'b1;
      set_inputs(32'h12345678, 1'b0, 8'hFF, 1'b0, 8'h00);
      repeat (3) @(negedge clk_i);

      // basic scan sequence
      pulse_reset();
      run_table();

      // hold across a frame start, then release
      pulse_reset();
      go(10);
      @(negedge clk_i) begin data_i = 32'hDEADBEEF; hold_i = 1'b1; end
      go(36);
      chk("hold_f2_an", {24'd0, an_o}, 32'hFE);
      chk("hold_f2_seg", {25'd0, seg_o}, 32'h00);
      $display("hold frame2 digit0 seg=%h", seg_o);
      @(negedge clk_i) hold_i = 1'b0;
      go(68);
      chk("hold_f3_seg0", {25'd0, seg_o}, 32'h0E);
      go(96);
      chk("hold_f3_an7", {24'd0, an_o}, 32'h7F);
      chk("hold_f3_seg7", {25'd0, seg_o}, 32'h21);
      $display("release frame3 digit7 an=%h seg=%h", an_o, seg_o);

      // leading-zero blanking
      @(negedge clk_i) set_inputs(32'h000000A0, 1'b0, 8'hFF, 1'b1, 8'h00);
      pulse_reset();
      go(4);
      chk("lz_d0_seg", {25'd0, seg_o}, 32'h40);
      go(8);
      chk("lz_d1_an", {24'd0, an_o}, 32'hFD);
      chk("lz_d1_seg", {25'd0, seg_o}, 32'h08);
      for (int t = 12; t <= 32; t += 4) begin
         go(t);
         chk("lz_hi_an", {24'd0, an_o}, 32'hFF);
      end
      $display("lz A0 frame done");
      @(negedge clk_i) data_i = 32'h0;
      pulse_reset();
      go(4);
      chk("lz0_d0_an", {24'd0, an_o}, 32'hFE);
      chk("lz0_d0_seg", {25'd0, seg_o}, 32'h40);
      go(8);
      chk("lz0_d1_an", {24'd0, an_o}, 32'hFF);
      $display("lz zero frame done");

      // enables and decimal points
      @(negedge clk_i) set_inputs(32'h12345678, 1'b0, 8'h0F, 1'b0, 8'h02);
      pulse_reset();
      for (int k = 0; k < 8; k++) begin
         go(4 * (k + 1));
         chk($sformatf("en_dp_d%0d", k), {31'd0, dp_o}, {31'd0, (k == 1) ? 1'b0 : 1'b1});
         if (k >= 4) begin
            chk($sformatf("en_an_d%0d", k), {24'd0, an_o}, 32'hFF);
            chk($sformatf("en_seg_d%0d", k), {25'd0, seg_o}, 32'h7F);
         end
         $display("enable digit %0d an=%h dp=%b", k, an_o, dp_o);
      end

      // reset while digit 5 is lit, then identical restart
      @(negedge clk_i) set_inputs(32'h12345678, 1'b0, 8'hFF, 1'b0, 8'h00);
      pulse_reset();
      go(25);
      chk("mid_pre_an", {24'd0, an_o}, 32'hDF);
      @(negedge clk_i) rst_i = 1'b1;
      step(1);
      chk("mid_rst_an", {24'd0, an_o}, 32'hFF);
      chk("mid_rst_seg", {25'd0, seg_o}, 32'h7F);
      chk("mid_rst_dp", {31'd0, dp_o}, 32'h1);
      chk("mid_rst_frame", {31'd0, frame_o}, 32'h0);
      $display("mid-frame reset applied");
      @(negedge clk_i) rst_i = 1'b0;
      run_table();

      // frame period and anode rotation over three frames
      pulse_reset();
      fr_edges.delete();
      for (int t = 1; t <= 100; t++) begin
         step(1);
         if (frame_o === 1'b1) fr_edges.push_back(t);
         if (t % DIV == 0) begin
            exp_an = 8'd1 << (((t / DIV) - 1) % 8);
            chk("rot_an", {24'd0, an_o}, {24'd0, ~exp_an});
         end
      end
      chk("period_count", fr_edges.size(), 4);
      for (int i = 0; i < fr_edges.size(); i++)
         chk("period_edge", fr_edges[i], 4 + 32 * i);
      $display("period test: %0d frame pulses", fr_edges.size());

      // random stimulus against the reference model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_i);
         rst_i = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 15) == 0) data_i = $urandom >> $urandom_range(0, 32);
         if ($urandom_range(0, 31) == 0) hold_i = $urandom_range(0, 1);
         if ($urandom_range(0, 40) == 0) dig_en_i = $urandom;
         if ($urandom_range(0, 40) == 0) lz_blank_i = $urandom_range(0, 1);
         if ($urandom_range(0, 40) == 0) dp_i = $urandom;
      end
      @(negedge clk_i) rst_i = 1'b0;
      step(2);
      $display("random phase done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Downstream consumer of the core's 32-bit debug value (register-file read port 1 output). Drives an 8-digit, common-anode, multiplexed seven-segment display with a time-multiplexed digit scan. The display value is latched once per scan frame, so a digit never shows a mix of old and new values. Supports per-digit enables, leading-zero blanking, decimal points and a freeze (hold) control.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit; legal range is REFRESH_DIV >= 2; prescaler width = $clog2(REFRESH_DIV).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
data_i  in  32  value to display; digit k shows nibble data[4k+3:4k]; digit 0 is rightmost (an_o[0])
hold_i  in  1  1 = do not reload the shadow value at frame start
dig_en_i  in  8  per-digit enable, 1 = digit may light
lz_blank_i  in  1  1 = blank leading zero digits
dp_i  in  8  per-digit decimal point, 1 = lit
an_o  out  8  digit anodes, active-low, at most one bit low
seg_o  out  7  {g,f,e,d,c,b,a}, active-low
dp_o  out  1  decimal point, active-low
frame_o  out  1  one-cycle pulse when digit 0 of a new frame is driven

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_i is sampled on the rising edge of clk_i.
  - Reset values: prescaler=0, digit index=7, shadow=0, active flag=0, an_o=8'hFF, seg_o=7'h7F, dp_o=1, frame_o=0.
  - Reset asserted mid-frame takes effect at the next edge and restarts the block identically.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and then wraps to 0.
  - tick is the cycle where prescaler == REFRESH_DIV-1.
- Digit index:
  - Advances on tick, 0→1→…→7→0.
  - The transition 7→0 is the frame start.
  - The first tick after reset is a frame start, because the index resets to 7.
- Frame start edge:
  - If hold_i=0, shadow <= data_i. If hold_i=1, shadow is unchanged.
  - active <= 1.
  - frame_o=1 for exactly the following cycle.
- Outputs:
  - All outputs are registered and update only on a tick edge.
  - Exception: frame_o returns to 0 one cycle after it is asserted.
- Latency:
  - After rst_i deasserts, the first digit appears at the REFRESH_DIV-th rising edge.
  - Until then all outputs stay at their reset values.
- Per tick edge, new index k, nibble n = shadow_next[4k+3:4k]:
  - A digit is lit iff active, dig_en_i[k]=1, and the digit is not LZ-blanked.
  - LZ-blanked means: lz_blank_i=1, k != 0, and nibbles k..7 of shadow_next are all zero. Digit 0 is never LZ-blanked.
  - Lit digit: an_o = ~(8'b1 << k), seg_o = decode(n), dp_o = ~dp_i[k].
  - Unlit digit: an_o=8'hFF, seg_o=7'h7F, dp_o=1.
  - dig_en_i, lz_blank_i and dp_i are sampled live at the tick; they are not shadowed.
- decode (hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Frame period: 8*REFRESH_DIV cycles. frame_o pulses with exactly this period.
- hold_i has no effect outside frame start edges.
- data_i changes mid-frame are invisible until the next frame start.

Test Plan:
- REFRESH_DIV=4, data_i=32'h12345678, hold=0, dig_en=FF, lz=0, dp=00, release reset:
  - Edges 1-3: an_o=FF, seg_o=7F.
  - Edge 4: an_o=FE, seg_o=00, frame_o=1 for one cycle.
  - Edge 8: an_o=FD, seg_o=78.
  - Edge 32: an_o=7F, seg_o=79.
  - Edge 36: an_o=FE, frame_o=1 again.
- Hold:
  - During frame 1, set data_i=32'hDEADBEEF and hold_i=1 → frame 2 digit 0 seg_o=00 (still 8).
  - Drop hold_i → frame 3 digit 0 seg_o=0E, digit 7 seg_o=21.
- LZ blanking, lz_blank_i=1:
  - data_i=32'h000000A0 → digits 2-7 an_o=FF, digit 1 seg_o=08, digit 0 seg_o=40.
  - data_i=0 → only digit 0 lit, seg_o=40.
- Enables and decimal points, dig_en_i=8'h0F, dp_i=8'h02:
  - Digits 4-7 → an_o=FF, seg_o=7F, dp_o=1.
  - Digit 1 → dp_o=0.
  - Digits 0, 2, 3 → dp_o=1.
- Reset mid-frame: pulse rst_i while digit 5 is lit → next edge an_o=FF, seg_o=7F, dp_o=1, frame_o=0; the restart sequence matches test 1 exactly.
- Wrap and period: run 3 frames → frame_o pulses exactly every 32 cycles; the anode pattern cycles FE,FD,FB,F7,EF,DF,BF,7F with no gaps or repeats.
